// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - receive-side half-period and flag checker for the LED blinker
module blink_monitor #(
  parameter int CBITS  = 22,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  input  logic             flg_in,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CBITS:0]   meas
);

  localparam int W = CBITS + 1;
  localparam logic [CBITS:0] HALF  = {1'b1, {CBITS{1'b0}}};
  localparam logic [CBITS:0] TOL_V = W'(TOL);
  localparam logic [CBITS:0] HI    = HALF + TOL_V;
  localparam logic [CBITS:0] LO    = HALF - TOL_V;
  localparam logic [CBITS:0] SAT   = HI + W'(1);
  localparam logic [3:0]     LOCK_V = 4'(LOCK_N);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, FAULT} state_t;

  state_t         state, state_nxt;
  logic           led_q, flg_q;
  logic [CBITS:0] cnt;
  logic [3:0]     good, good_inc;
  logic           edge_det, checking;
  logic           flg_f, long_f, short_f;
  logic           fault, good_e;
  logic [1:0]     cause;

  always_comb begin
    edge_det = led_in ^ led_q;
    checking = (state == MEASURE) || (state == LOCKED);
    flg_f    = edge_det != flg_q;
    // timeout fires once, on the cycle cnt sits at the upper limit without an edge
    long_f   = edge_det ? (cnt > HI) : (cnt == HI);
    short_f  = edge_det && (cnt < LO);
    fault    = checking && (flg_f || long_f || short_f);
    good_e   = checking && edge_det && !flg_f && !long_f && !short_f;
    good_inc = good + 4'd1;
    if (flg_f)       cause = 2'b11;
    else if (long_f) cause = 2'b10;
    else             cause = 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (edge_det) state_nxt = MEASURE;
      MEASURE: begin
        if (fault)                                state_nxt = FAULT;
        else if (good_e && (good_inc == LOCK_V))  state_nxt = LOCKED;
      end
      LOCKED:  if (fault) state_nxt = FAULT;
      FAULT:   if (edge_det) state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q    <= 1'b0;
      flg_q    <= 1'b0;
      cnt      <= '0;
      good     <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
      meas     <= '0;
    end else begin
      led_q <= led_in;
      flg_q <= flg_in;
      if (edge_det)        cnt <= W'(1);
      else if (cnt != SAT) cnt <= cnt + W'(1);
      if (((state == IDLE) || (state == FAULT)) && edge_det) good <= '0;
      else if ((state == MEASURE) && good_e)                 good <= good_inc;
      if (edge_det && (state != IDLE)) meas <= cnt;
      err <= fault;
      if (fault) err_code <= cause;
    end
  end

endmodule

// File: doc/blink_monitor.md
# blink_monitor

Receive-side checker for the LED blinker. It samples the blinker's `led` and `flg` outputs and measures each LED half-period. It checks every half-period against the nominal 2^CBITS cycles within a tolerance, and checks that every LED toggle is announced by a `flg` pulse exactly one cycle earlier. It reports lock after a run of good half-periods and flags faults with a one-cycle pulse and a sticky error code. It sits next to the blinker in the same clock domain, and its outputs feed status logic and formal liveness checks.

## Interface
- `CBITS`, 22: blinker counter width; nominal half-period HALF = 2^CBITS cycles.
- `TOL`, 2: allowed deviation in cycles; legal range 0 <= TOL < 2^(CBITS-1).
- `LOCK_N`, 4: consecutive in-tolerance half-periods required for lock; range 1..15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `led_in`  in  1  blinker LED output, same clock domain, no synchronizer.
- `flg_in`  in  1  blinker wrap flag, same clock domain.
- `locked`  out  1  high while in LOCKED.
- `err`  out  1  one-cycle pulse on each detected fault.
- `err_code`  out  2  sticky cause of the last fault: 00 none, 01 SHORT, 10 LONG, 11 FLG.
- `meas`  out  CBITS+1  last measured half-period in cycles.

## Operation
- Internal registers:
  - `led_q` holds the previous `led_in`.
  - `flg_q` holds the previous `flg_in`.
  - `cnt` is CBITS+1 bits.
  - `good` is 4 bits.
  - `state` takes one of IDLE, MEASURE, LOCKED, FAULT.
- Edge: `edge` = (`led_in` != `led_q`), evaluated every cycle.
- Counter:
  - On `edge`, `cnt` <= 1.
  - Otherwise `cnt` increments, saturating at HALF+TOL+1.
  - The interval between two edge cycles t and t+P therefore yields P.
- Classification, applied in MEASURE and LOCKED only, with priority FLG > LONG > SHORT:
  - FLG: `edge` != `flg_q`. This covers an edge without a preceding `flg`, and a `flg` not followed by an edge.
  - LONG: `edge` with `cnt` > HALF+TOL, or no `edge` while `cnt` == HALF+TOL (timeout, fires once).
  - SHORT: `edge` with `cnt` < HALF-TOL.
  - Good: `edge` with HALF-TOL <= `cnt` <= HALF+TOL and no FLG.
- `meas` <= `cnt` on every `edge` outside IDLE, whether the edge is good or faulty.
- State transitions:
  - IDLE: on `edge` go to MEASURE with `good` = 0. No checks run in IDLE, so a spurious first edge caused by the reset value of `led_q` is harmless.
  - MEASURE:
    - On a good edge, `good` increments; when it reaches LOCK_N go to LOCKED.
    - On any fault go to FAULT.
  - LOCKED:
    - On a good edge, stay.
    - On any fault go to FAULT; `locked` drops.
  - FAULT:
    - No checks run and `cnt` keeps counting or saturating.
    - On `edge` go to MEASURE with `good` = 0; this edge is not classified and `meas` is updated.
- On each fault, `err` pulses for one cycle and `err_code` <= cause. `err_code` is cleared only by reset.

## Timing
- Reset values:
  - Outputs: `locked` = 0, `err` = 0, `err_code` = 00, `meas` = 0.
  - Internal: `led_q` = 0, `flg_q` = 0, `cnt` = 0, `good` = 0, state IDLE.
- Reset asserted mid-operation returns everything to the reset values immediately, without waiting for a clock edge.
- All outputs are registered. A condition detected at clock edge k appears on the outputs right after edge k (latency 1 from the input sample).
- `locked` rises at the same edge where `good` reaches LOCK_N.
- A connected blinker raises `flg` one cycle before `led` toggles, so `flg_q` and `edge` coincide.
- Timeout fires at the edge where `cnt` == HALF+TOL and no edge occurs, which is exactly one cycle before a late edge would have been classified LONG. No second `err` follows for that late edge, because FAULT does not check.
- The boundary intervals HALF-TOL and HALF+TOL are both good.
- Back-to-back faults are impossible: FAULT always requires an edge before checking resumes.

## Test plan
All scenarios use CBITS=4 (HALF=16), TOL=1, LOCK_N=3, with `rst` released at cycle 0.
- Connected blinker (CBITS=4):
  - First edge → MEASURE.
  - Three half-periods of 16 → `locked` = 1, `meas` = 16, `err` never pulses.
- Stimulus half-periods of 15, 17, 15 with correct `flg` → locked (tolerance boundary). A following half-period of 14 → `err` pulse, `err_code` = 01, `locked` = 0, `meas` = 14.
- While locked, `led_in` held constant → `err` pulses exactly when `cnt` = 17, `err_code` = 10. A later edge → MEASURE, `meas` = 18, no further `err`.
- While locked, `flg` suppressed before an on-time edge → `err`, `err_code` = 11. A `flg` pulse with no following edge → also `err_code` = 11.
- Fault then recovery: after an `err_code` = 01 fault, three good periods → `locked` = 1 again, `err_code` stays 01.
- `rst` asserted mid-count while locked → all outputs 0 asynchronously. After release, the monitor requires 1+LOCK_N edges to relock.
